// File: rtl/vlg_pulse_gen_pkg.sv
// Shared types and default widths for the pulse-train transmitter.
package vlg_pulse_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_WID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vlg_pulse_gen_if.sv
// Control/status bundle between a train requester and vlg_pulse_gen.
interface vlg_pulse_gen_if
    import vlg_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WID_W = DEF_WID_W
);
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_pulse_num;
    logic [WID_W-1:0] i_high_cyc;
    logic [WID_W-1:0] i_low_cyc;
    logic             o_pulse;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_sent_cnt;

    modport master (
        output i_start, i_abort, i_pulse_num, i_high_cyc, i_low_cyc,
        input  o_pulse, o_busy, o_done, o_sent_cnt
    );

    modport slave (
        input  i_start, i_abort, i_pulse_num, i_high_cyc, i_low_cyc,
        output o_pulse, o_busy, o_done, o_sent_cnt
    );
endinterface

// File: rtl/vlg_pulse_gen_width_timer.sv
// Down-counting phase timer: loading V makes expire pulse V cycles later.
module vlg_width_timer
    import vlg_pulse_pkg::*;
#(
    parameter int WID_W = DEF_WID_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             load,
    input  logic [WID_W-1:0] value,
    output logic             expire
);
    logic [WID_W-1:0] cnt_q;

    // Count down to zero and park there; a load always overrides.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WID_W'(1);
        end
    end

    assign expire = (cnt_q == WID_W'(1));
endmodule

// File: rtl/vlg_pulse_gen.sv
// Programmable pulse-train transmitter.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   HIGH  | o_pulse driven high for H' cycles
//   LOW   | o_pulse driven low for L' cycles
//   DONE  | one-cycle completion strobe
module vlg_pulse_gen
    import vlg_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WID_W = DEF_WID_W
) (
    input logic            i_clk,
    input logic            i_rst_n,
    vlg_pulse_gen_if.slave bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [WID_W-1:0] high_q, high_d;
    logic [WID_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             pulse_q, busy_q, done_q;
    logic [WID_W-1:0] high_eff, low_eff;
    logic             tmr_load;
    logic [WID_W-1:0] tmr_val;
    logic             tmr_expire;

    // A zero width would never expire the timer, so it is promoted to one.
    assign high_eff = (bus.i_high_cyc == '0) ? WID_W'(1) : bus.i_high_cyc;
    assign low_eff  = (bus.i_low_cyc  == '0) ? WID_W'(1) : bus.i_low_cyc;

    vlg_width_timer #(.WID_W(WID_W)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (tmr_load),
        .value   (tmr_val),
        .expire  (tmr_expire)
    );

    // Next-state, parameter latch and timer control; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        high_d   = high_q;
        low_d    = low_q;
        sent_d   = sent_q;
        tmr_load = 1'b0;
        tmr_val  = high_q;
        if (bus.i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        num_d  = bus.i_pulse_num;
                        high_d = high_eff;
                        low_d  = low_eff;
                        if (bus.i_pulse_num == '0) begin
                            sent_d  = '0;
                            state_d = ST_DONE;
                        end else begin
                            // cleared and incremented for the first pulse at once
                            sent_d   = CNT_W'(1);
                            state_d  = ST_HIGH;
                            tmr_load = 1'b1;
                            tmr_val  = high_eff;
                        end
                    end
                end
                ST_HIGH: begin
                    if (tmr_expire) begin
                        state_d  = ST_LOW;
                        tmr_load = 1'b1;
                        tmr_val  = low_q;
                    end
                end
                ST_LOW: begin
                    if (tmr_expire) begin
                        if (sent_q == num_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_HIGH;
                            sent_d   = sent_q + CNT_W'(1);
                            tmr_load = 1'b1;
                            tmr_val  = high_q;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, latched parameters and registered outputs decoded from next state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            sent_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            high_q  <= high_d;
            low_q   <= low_d;
            sent_q  <= sent_d;
            pulse_q <= (state_d == ST_HIGH);
            busy_q  <= (state_d == ST_HIGH) || (state_d == ST_LOW);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.o_pulse    = pulse_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_sent_cnt = sent_q;
endmodule

// File: tb/tb_vlg_pulse_gen.sv
// Directed bench for vlg_pulse_gen with a downstream rising-edge counter.
module tb_vlg_pulse_gen;
    import vlg_pulse_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   e0;
    logic pulse_prev = 1'b0;

    vlg_pulse_gen_if #(.CNT_W(16), .WID_W(8)) bus ();

    vlg_pulse_gen #(.CNT_W(16), .WID_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    // Models the downstream pulse counter.
    always @(negedge i_clk) begin
        if (bus.o_pulse && !pulse_prev) edge_cnt = edge_cnt + 1;
        pulse_prev = bus.o_pulse;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int sent);
        chk({tag, "_pulse"}, 32'(bus.o_pulse), 32'd0);
        chk({tag, "_busy"},  32'(bus.o_busy),  32'd0);
        chk({tag, "_done"},  32'(bus.o_done),  32'd0);
        chk({tag, "_sent"},  32'(bus.o_sent_cnt), 32'(sent));
    endtask

    task automatic start_train(input int n, input int h, input int l);
        bus.i_pulse_num = 16'(n);
        bus.i_high_cyc  = 8'(h);
        bus.i_low_cyc   = 8'(l);
        bus.i_start     = 1'b1;
        e0 = edge_cnt;
        tick();
        bus.i_start     = 1'b0;
    endtask

    // pat holds cycles 1..busy_len+1 MSB first; done expected right after busy.
    task automatic check_train(input string tag, input logic [31:0] pat, input int busy_len);
        for (int c = 1; c <= busy_len + 1; c++) begin
            chk({tag, "_pulse"}, 32'(pat[busy_len + 1 - c]), 32'(bus.o_pulse));
            chk({tag, "_busy"},  32'(bus.o_busy), 32'(c <= busy_len));
            chk({tag, "_done"},  32'(bus.o_done), 32'(c == busy_len + 1));
            tick();
        end
    endtask

    initial begin
        i_rst_n         = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_pulse_num = '0;
        bus.i_high_cyc  = '0;
        bus.i_low_cyc   = '0;
        tick();
        tick();
        chk_idle("reset", 0);
        i_rst_n = 1'b1;
        tick();

        // N=3 H=2 L=1 -> 110110110, done on cycle 10
        start_train(3, 2, 1);
        chk("t1_sent_c1", 32'(bus.o_sent_cnt), 32'd1);
        check_train("t1", 32'b1101101100, 9);
        chk_idle("t1_end", 3);
        chk("t1_edges", 32'(edge_cnt - e0), 32'd3);

        // N=0 -> done in cycle 1, never busy
        start_train(0, 4, 4);
        chk("t2_done", 32'(bus.o_done), 32'd1);
        chk("t2_busy", 32'(bus.o_busy), 32'd0);
        chk("t2_pulse", 32'(bus.o_pulse), 32'd0);
        chk("t2_sent", 32'(bus.o_sent_cnt), 32'd0);
        tick();
        chk_idle("t2_end", 0);

        // H=L=0 N=2 -> 1010, done on cycle 5
        start_train(2, 0, 0);
        check_train("t3", 32'b10100, 4);
        chk_idle("t3_end", 2);
        chk("t3_edges", 32'(edge_cnt - e0), 32'd2);

        // N=5 H=3 L=3, abort in busy cycle 8
        start_train(5, 3, 3);
        for (int c = 1; c <= 8; c++) begin
            chk("t4_busy", 32'(bus.o_busy), 32'd1);
            if (c == 4) chk("t4_pulse_c4", 32'(bus.o_pulse), 32'd0);
            if (c == 8) bus.i_abort = 1'b1;
            else tick();
        end
        tick();
        bus.i_abort = 1'b0;
        chk_idle("t4_abort", 2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_no_done", 32'(bus.o_done), 32'd0);
        end
        start_train(1, 1, 1);
        check_train("t4_restart", 32'b100, 2);
        chk_idle("t4_restart_end", 1);

        // start+abort in the same IDLE cycle is dropped
        bus.i_pulse_num = 16'd9;
        bus.i_start     = 1'b1;
        bus.i_abort     = 1'b1;
        tick();
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        chk_idle("t5_drop", 1);
        tick();
        chk_idle("t5_drop2", 1);

        // start re-pulsed mid-train with different settings is ignored
        start_train(2, 2, 2);
        for (int c = 1; c <= 9; c++) begin
            chk("t5_pulse", 32'(bus.o_pulse), 32'((c <= 2) || (c == 5) || (c == 6)));
            chk("t5_busy",  32'(bus.o_busy), 32'(c <= 8));
            chk("t5_done",  32'(bus.o_done), 32'(c == 9));
            if (c == 3) begin
                bus.i_start     = 1'b1;
                bus.i_pulse_num = 16'd7;
                bus.i_high_cyc  = 8'd1;
            end else begin
                bus.i_start = 1'b0;
            end
            tick();
        end
        chk_idle("t5_end", 2);

        // reset during LOW after pulse 2 of N=4 H=1 L=1
        start_train(4, 1, 1);
        chk("t6_c1", 32'(bus.o_pulse), 32'd1);
        tick();
        chk("t6_c2", 32'(bus.o_pulse), 32'd0);
        tick();
        chk("t6_c3", 32'(bus.o_pulse), 32'd1);
        chk("t6_sent_c3", 32'(bus.o_sent_cnt), 32'd2);
        tick();
        chk("t6_c4", 32'(bus.o_busy), 32'd1);
        i_rst_n = 1'b0;
        tick();
        chk_idle("t6_rst", 0);
        i_rst_n = 1'b1;
        tick();
        tick();
        chk_idle("t6_after", 0);
        start_train(1, 1, 1);
        check_train("t6_restart", 32'b100, 2);
        chk_idle("t6_restart_end", 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
